// File: rtl/colocador_frota_pkg.sv
// Shared definitions for fleet placement: ship types, board limit, error codes
// and controller state encoding, also used by the placement validator.
package colocador_frota_pkg;

  localparam int NAVIOS_POR_JOGADOR = 11;
  localparam logic [3:0] LIMITE_TABULEIRO = 4'd7;

  localparam logic [2:0] TIPO_SUBMARINO         = 3'b000;
  localparam logic [2:0] TIPO_CONTRATORPEDEIRO  = 3'b001;
  localparam logic [2:0] TIPO_HIDROAVIAO        = 3'b010;
  localparam logic [2:0] TIPO_CRUZADOR          = 3'b011;
  localparam logic [2:0] TIPO_PORTA_AVIOES      = 3'b100;

  typedef enum logic [1:0] {
    ERRO_NENHUM   = 2'b00,
    ERRO_CONFLITO = 2'b01,
    ERRO_FORA     = 2'b10,
    ERRO_TIMEOUT  = 2'b11
  } erro_t;

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA_CONF,
    VALIDA,
    LIBERA,
    FIM
  } estado_t;

  // Fleet schedule: five submarines, two destroyers, two seaplanes,
  // one cruiser and one carrier, in that order.
  function automatic logic [2:0] tipo_do_navio(input logic [3:0] idx);
    if (idx <= 4'd4)      return TIPO_SUBMARINO;
    else if (idx <= 4'd6) return TIPO_CONTRATORPEDEIRO;
    else if (idx <= 4'd8) return TIPO_HIDROAVIAO;
    else if (idx == 4'd9) return TIPO_CRUZADOR;
    else                  return TIPO_PORTA_AVIOES;
  endfunction

endpackage

// File: rtl/colocador_frota_detector_borda.sv
// One-cycle pulse on the rising edge of an already-synchronous input.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal,
  output logic pulso
);

  logic anterior;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) anterior <= 1'b0;
    else        anterior <= sinal;
  end

  assign pulso = sinal & ~anterior;

endmodule

// File: rtl/colocador_frota.sv
// Fleet placement controller: walks both players through their ship lists,
// hands each confirmed placement to the validator and records the verdict.
module colocador_frota
  import colocador_frota_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 32,
  parameter int NUM_NAVIOS     = NAVIOS_POR_JOGADOR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicia,
  input  logic       confirma,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       direcao_in,
  input  logic [2:0] orientacao_in,
  input  logic       ready,
  input  logic       conflito,
  output logic       enable,
  output logic [2:0] tipo,
  output logic       direcao,
  output logic [2:0] orientacao,
  output logic [3:0] x1,
  output logic [3:0] y1,
  output logic       jogador,
  output logic [3:0] navio_idx,
  output logic [1:0] erro,
  output logic       fim
);

  localparam logic [3:0] TOTAL_IDX   = 4'(NUM_NAVIOS);
  localparam logic [4:0] LIMITE_CONT = 5'(TIMEOUT_CICLOS - 1);

  estado_t    estado;
  logic [4:0] contador;
  logic       confirma_pulso;

  detector_borda u_detector_borda (
    .clk   (clk),
    .rst_n (rst_n),
    .sinal (confirma),
    .pulso (confirma_pulso)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      enable     <= 1'b0;
      tipo       <= TIPO_SUBMARINO;
      direcao    <= 1'b0;
      orientacao <= 3'b000;
      x1         <= 4'd0;
      y1         <= 4'd0;
      jogador    <= 1'b0;
      navio_idx  <= 4'd0;
      erro       <= ERRO_NENHUM;
      fim        <= 1'b0;
      contador   <= 5'd0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (inicia) begin
            estado    <= ESPERA_CONF;
            jogador   <= 1'b0;
            navio_idx <= 4'd0;
            tipo      <= tipo_do_navio(4'd0);
            erro      <= ERRO_NENHUM;
            fim       <= 1'b0;
          end
        end

        ESPERA_CONF: begin
          if (confirma_pulso) begin
            if (x_in > LIMITE_TABULEIRO || y_in > LIMITE_TABULEIRO) begin
              erro <= ERRO_FORA;
            end else begin
              // Only types that care about direction/orientation see the player's choice.
              x1         <= x_in;
              y1         <= y_in;
              direcao    <= (tipo == TIPO_SUBMARINO) ? 1'b0 : direcao_in;
              orientacao <= (tipo == TIPO_HIDROAVIAO) ? orientacao_in : 3'b000;
              erro       <= ERRO_NENHUM;
              enable     <= 1'b1;
              contador   <= 5'd0;
              estado     <= VALIDA;
            end
          end
        end

        VALIDA: begin
          if (ready) begin
            if (conflito) begin
              erro <= ERRO_CONFLITO;
            end else begin
              erro      <= ERRO_NENHUM;
              navio_idx <= navio_idx + 4'd1;
              tipo      <= tipo_do_navio(navio_idx + 4'd1);
            end
            enable   <= 1'b0;
            contador <= 5'd0;
            estado   <= LIBERA;
          end else if (contador == LIMITE_CONT) begin
            erro     <= ERRO_TIMEOUT;
            enable   <= 1'b0;
            contador <= 5'd0;
            estado   <= LIBERA;
          end else begin
            contador <= contador + 5'd1;
          end
        end

        LIBERA: begin
          if (navio_idx < TOTAL_IDX) begin
            estado <= ESPERA_CONF;
          end else if (!jogador) begin
            jogador   <= 1'b1;
            navio_idx <= 4'd0;
            tipo      <= tipo_do_navio(4'd0);
            estado    <= ESPERA_CONF;
          end else begin
            fim    <= 1'b1;
            estado <= FIM;
          end
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_colocador_frota.sv
// Scoreboard-driven bench for the fleet placement controller with a simple
// validator model answering from the bench side.
module tb_colocador_frota;

  logic       clk;
  logic       rst_n;
  logic       inicia;
  logic       confirma;
  logic [3:0] x_in;
  logic [3:0] y_in;
  logic       direcao_in;
  logic [2:0] orientacao_in;
  logic       ready;
  logic       conflito;
  logic       enable;
  logic [2:0] tipo;
  logic       direcao;
  logic [2:0] orientacao;
  logic [3:0] x1;
  logic [3:0] y1;
  logic       jogador;
  logic [3:0] navio_idx;
  logic [1:0] erro;
  logic       fim;

  colocador_frota #(.TIMEOUT_CICLOS(32), .NUM_NAVIOS(11)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inicia        (inicia),
    .confirma      (confirma),
    .x_in          (x_in),
    .y_in          (y_in),
    .direcao_in    (direcao_in),
    .orientacao_in (orientacao_in),
    .ready         (ready),
    .conflito      (conflito),
    .enable        (enable),
    .tipo          (tipo),
    .direcao       (direcao),
    .orientacao    (orientacao),
    .x1            (x1),
    .y1            (y1),
    .jogador       (jogador),
    .navio_idx     (navio_idx),
    .erro          (erro),
    .fim           (fim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tipo;
    logic       d;
    logic [2:0] o;
    logic [3:0] x;
    logic [3:0] y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_idx = 0;
  logic exp_jog = 1'b0;
  logic exp_fim = 1'b0;
  logic [2:0] tipo_tab [0:10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};

  // Pushes the expected latched placement, pulses confirm and checks what the validator sees.
  task automatic confirm_and_check(input logic [3:0] x, input logic [3:0] y,
                                   input logic d, input logic [2:0] o);
    exp_t e;
    e.tipo = tipo_tab[exp_idx];
    e.x    = x;
    e.y    = y;
    e.d    = (e.tipo == 3'd0) ? 1'b0 : d;
    e.o    = (e.tipo == 3'd2) ? o : 3'b000;
    sb.push_back(e);
    @(negedge clk);
    x_in = x; y_in = y; direcao_in = d; orientacao_in = o; confirma = 1'b1;
    @(negedge clk);
    confirma = 1'b0;
    checks++;
    if (enable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL enable_rise idx=%0d got=%b want=1", exp_idx, enable);
    end
    e = sb.pop_front();
    checks++;
    if ({tipo, direcao, orientacao, x1, y1} !== {e.tipo, e.d, e.o, e.x, e.y}) begin
      failures++;
      $display("[TB] FAIL latched idx=%0d got tipo=%0d d=%b o=%b x=%0d y=%0d want tipo=%0d d=%b o=%b x=%0d y=%0d",
               exp_idx, tipo, direcao, orientacao, x1, y1, e.tipo, e.d, e.o, e.x, e.y);
    end
  endtask

  task automatic resolve(input logic conf, input int lat);
    repeat (lat - 1) @(negedge clk);
    ready = 1'b1; conflito = conf;
    @(negedge clk);
    ready = 1'b0; conflito = 1'b0;
    if (!conf) exp_idx++;
    checks++;
    if ({enable, navio_idx, erro} !== {1'b0, 4'(exp_idx), conf ? 2'b01 : 2'b00}) begin
      failures++;
      $display("[TB] FAIL verdict got en=%b idx=%0d erro=%b want en=0 idx=%0d erro=%b",
               enable, navio_idx, erro, exp_idx, conf ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    if (exp_idx == 11) begin
      if (!exp_jog) begin exp_jog = 1'b1; exp_idx = 0; end
      else exp_fim = 1'b1;
    end
    checks++;
    if ({enable, jogador, navio_idx, fim} !== {1'b0, exp_jog, 4'(exp_idx), exp_fim}) begin
      failures++;
      $display("[TB] FAIL release got en=%b jog=%b idx=%0d fim=%b want en=0 jog=%b idx=%0d fim=%b",
               enable, jogador, navio_idx, fim, exp_jog, exp_idx, exp_fim);
    end
  endtask

  task automatic place_ship(input logic d, input logic [2:0] o, input logic conf);
    confirm_and_check(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), d, o);
    resolve(conf, 3);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inicia = 1'b0; confirma = 1'b0; x_in = 4'd0; y_in = 4'd0;
    direcao_in = 1'b0; orientacao_in = 3'd0; ready = 1'b0; conflito = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx, erro, fim} !== 24'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h want=0",
               {enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx, erro, fim});
    end
    rst_n = 1'b1;
    exp_idx = 0; exp_jog = 1'b0; exp_fim = 1'b0;
  endtask

  task automatic test_start;
    @(negedge clk);
    inicia = 1'b1;
    @(negedge clk);
    inicia = 1'b0;
    exp_idx = 0; exp_jog = 1'b0; exp_fim = 1'b0;
    checks++;
    if ({enable, jogador, navio_idx, erro, fim, tipo} !== 12'd0) begin
      failures++;
      $display("[TB] FAIL start got en=%b jog=%b idx=%0d erro=%b fim=%b tipo=%0d want all 0",
               enable, jogador, navio_idx, erro, fim, tipo);
    end
  endtask

  task automatic test_player_one;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin
        @(negedge clk); inicia = 1'b1;
        @(negedge clk); inicia = 1'b0;
        checks++;
        if (navio_idx !== 4'd3) begin
          failures++;
          $display("[TB] FAIL inicia_ignored got idx=%0d want 3", navio_idx);
        end
      end
      if (i == 5) place_ship(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
      place_ship(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
    end
  endtask

  task automatic test_out_of_range;
    logic seen;
    @(negedge clk);
    x_in = 4'd8; y_in = 4'd2; confirma = 1'b1;
    @(negedge clk);
    confirma = 1'b0;
    checks++;
    if ({enable, erro} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL out_of_range got en=%b erro=%b want en=0 erro=10", enable, erro);
    end
    seen = 1'b0;
    ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      ready = 1'b0;
      seen |= enable;
    end
    checks++;
    if ({seen, navio_idx, jogador} !== {1'b0, 4'(exp_idx), exp_jog}) begin
      failures++;
      $display("[TB] FAIL no_enable got seen=%b idx=%0d jog=%b want seen=0 idx=%0d jog=%b",
               seen, navio_idx, jogador, exp_idx, exp_jog);
    end
  endtask

  task automatic test_timeout;
    int high;
    confirm_and_check(4'd7, 4'd7, 1'b1, 3'b011);
    high = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!enable) break;
      high++;
    end
    checks++;
    if (high != 32) begin
      failures++;
      $display("[TB] FAIL timeout_len got=%0d want=32", high);
    end
    checks++;
    if ({erro, navio_idx} !== {2'b11, 4'(exp_idx)}) begin
      failures++;
      $display("[TB] FAIL timeout_erro got erro=%b idx=%0d want erro=11 idx=%0d", erro, navio_idx, exp_idx);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_release got en=%b want 0", enable);
    end
  endtask

  task automatic test_reset_mid_valida;
    repeat (3) place_ship(1'b1, 3'b101, 1'b0);
    confirm_and_check(4'd1, 4'd2, 1'b1, 3'b101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx, erro, fim} !== 24'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_valida got=%h want=0",
               {enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx, erro, fim});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_idx = 0; exp_jog = 1'b0; exp_fim = 1'b0;
  endtask

  task automatic test_full_run;
    test_start();
    for (int i = 0; i < 22; i++) place_ship(1'b1, 3'b101, 1'b0);
    checks++;
    if ({fim, jogador, navio_idx} !== {1'b1, 1'b1, 4'd11}) begin
      failures++;
      $display("[TB] FAIL full_run got fim=%b jog=%b idx=%0d want fim=1 jog=1 idx=11", fim, jogador, navio_idx);
    end
  endtask

  task automatic test_fim_restart;
    @(negedge clk); x_in = 4'd1; y_in = 4'd1; confirma = 1'b1;
    @(negedge clk); confirma = 1'b0;
    @(negedge clk);
    checks++;
    if ({enable, fim} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL fim_confirm_ignored got en=%b fim=%b want en=0 fim=1", enable, fim);
    end
    test_start();
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_player_one();
    test_out_of_range();
    test_timeout();
    test_reset_mid_valida();
    test_full_run();
    test_fim_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/colocador_frota.md
COLOCADOR_FROTA -- requirements
Module: colocador_frota

Interface
- REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 32, max cycles to wait for validator ready.
- REQ-002 SHALL have parameter NUM_NAVIOS, default 11, ships per player.
- REQ-003 clk  in  1  sole clock, rising edge.
- REQ-004 rst_n  in  1  reset, asynchronous, active-low.
- REQ-005 inicia  in  1  level; starts placement session from OCIOSO or FIM.
- REQ-006 confirma  in  1  player confirm button, already synchronous; action on rising edge only.
- REQ-007 x_in, y_in  in  4 each  requested bow coordinate.
- REQ-008 direcao_in  in  1  requested direction.
- REQ-009 orientacao_in  in  3  requested orientation.
- REQ-010 ready  in  1  validator finished current check.
- REQ-011 conflito  in  1  validator verdict, valid while ready=1.
- REQ-012 enable  out  1  request to validator.
- REQ-013 tipo  out  3  ship type for current index.
- REQ-014 direcao  out  1; orientacao  out  3; x1, y1  out  4 each  latched placement to validator.
- REQ-015 jogador  out  1  0 = player one, 1 = player two.
- REQ-016 navio_idx  out  4  ship index 0..10 within current player.
- REQ-017 erro  out  2  00 none, 01 conflict, 10 out of range, 11 timeout.
- REQ-018 fim  out  1  both fleets placed.

Function
- REQ-019 Fleet schedule SHALL be: idx 0-4 tipo 000, 5-6 tipo 001, 7-8 tipo 010, idx 9 tipo 011, idx 10 tipo 100.
- REQ-020 States SHALL be OCIOSO, ESPERA_CONF, VALIDA, LIBERA, FIM; all outputs registered.
- REQ-021 OCIOSO: inicia=1 -> ESPERA_CONF next cycle, jogador=0, navio_idx=0, erro=00, fim=0.
- REQ-022 ESPERA_CONF, confirma rising edge with x_in>7 or y_in>7: erro=10, stay, enable stays 0.
- REQ-023 ESPERA_CONF, confirma rising edge in range: latch x1, y1, direcao, orientacao, set erro=00, enter VALIDA with enable=1 on the following edge.
- REQ-024 direcao SHALL be forced 0 for tipo 000; orientacao SHALL be forced 000 unless tipo=010.
- REQ-025 VALIDA: enable=1 held; 5-bit counter increments each cycle from 0.
- REQ-026 VALIDA, ready=1, conflito=0: navio_idx increments, erro=00, -> LIBERA.
- REQ-027 VALIDA, ready=1, conflito=1: navio_idx unchanged, erro=01, -> LIBERA.
- REQ-028 VALIDA, counter reaches TIMEOUT_CICLOS-1 with ready=0: erro=11, navio_idx unchanged, -> LIBERA.
- REQ-029 LIBERA: enable=0 for exactly one cycle; then navio_idx<NUM_NAVIOS -> ESPERA_CONF.
- REQ-030 LIBERA with navio_idx=NUM_NAVIOS and jogador=0: jogador=1, navio_idx=0 -> ESPERA_CONF.
- REQ-031 LIBERA with navio_idx=NUM_NAVIOS and jogador=1: -> FIM, fim=1, navio_idx held at 11.
- REQ-032 FIM: inicia=1 restarts as REQ-021; fim clears.
- REQ-033 confirma edges during VALIDA, LIBERA, FIM, OCIOSO SHALL be ignored, not queued.
- REQ-034 inicia outside OCIOSO/FIM SHALL be ignored.
- REQ-035 ready asserted outside VALIDA SHALL be ignored.

Reset
- REQ-036 rst_n=0 SHALL immediately force state OCIOSO, enable=0, tipo=000, direcao=0, orientacao=000, x1=y1=0, jogador=0, navio_idx=0, erro=00, fim=0, counter=0, edge-detect register=0.
- REQ-037 Reset asserted mid-VALIDA SHALL drop enable without waiting for ready; no ship counted.

Structure
- REQ-038 Shared package SHALL hold tipo codes, NUM_NAVIOS, board limit 7, erro codes and state encoding, shared with the validator.
- REQ-039 Sub-module detector_borda SHALL produce the one-cycle confirma rising-edge pulse.

Verification
- REQ-040 Reset, inicia, then 11 in-range confirms with validator model answering ready=1/conflito=0 after 3 cycles -> tipo sequence 0,0,0,0,0,1,1,2,2,3,4, jogador flips to 1 with navio_idx=0.
- REQ-041 Confirm x_in=8, y_in=2 -> erro=10, enable never rises, navio_idx unchanged.
- REQ-042 Validator returns conflito=1 at idx 5 -> erro=01, idx stays 5; reconfirm with conflito=0 -> idx=6, erro=00.
- REQ-043 Validator never raises ready -> enable high exactly 32 cycles, erro=11, then enable=0 one cycle.
- REQ-044 Full 22-ship run -> fim=1; tipo=000 with direcao_in=1 drives direcao=0; tipo=001 with orientacao_in=101 drives orientacao=000.
- REQ-045 rst_n low mid-VALIDA at idx 3 of player two -> enable=0 same cycle, all outputs at reset values.
